// File: rtl/ahb_mtx_req_stage_pkg.sv
// ahb_mtx_req_stage_pkg: shared AHB codes, FSM encoding and captured-control type for the matrix request stage
package ahb_mtx_req_stage_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_GNT = 3'd1,
        ST_DATA     = 3'd2,
        ST_ERR1     = 3'd3,
        ST_ERR2     = 3'd4
    } state_e;

    typedef struct packed {
        logic [1:0] htrans;
        logic       hwrite;
        logic [2:0] hsize;
        logic [2:0] hburst;
        logic [3:0] hprot;
    } ctl_t;

    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_mtx_addr_dec.sv
// ahb_mtx_addr_dec: combinational address decode to slave-port hit vector, lowest-index winner and miss flag
module ahb_mtx_addr_dec #(
    parameter int                            SLV_NUM    = 2,
    parameter int                            ADDR_WIDTH = 32,
    parameter int                            IDX_W      = 1,
    parameter logic [ADDR_WIDTH*SLV_NUM-1:0] SLV_BASE   = {32'h2000_0000, 32'h0000_0000},
    parameter logic [ADDR_WIDTH*SLV_NUM-1:0] SLV_MASK   = {32'hF000_0000, 32'hF000_0000}
) (
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    output logic [SLV_NUM-1:0]    hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  miss_o
);

    for (genvar g = 0; g < SLV_NUM; g++) begin : g_hit
        assign hit_o[g] = (haddr_i & SLV_MASK[g*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Scan downward so the lowest-index overlapping region is the one left standing
    always_comb begin
        idx_o = '0;
        for (int s = SLV_NUM - 1; s >= 0; s--)
            if (hit_o[s]) idx_o = IDX_W'(s);
    end

    assign miss_o = ~|hit_o;

endmodule

// File: rtl/ahb_mtx_req_stage.sv
// ahb_mtx_req_stage: master-side matrix input stage; captures the address phase, requests the target
// slave-port arbiter, stalls the master until granted, forwards the phase and returns the response.
module ahb_mtx_req_stage
    import ahb_mtx_req_stage_pkg::*;
#(
    parameter int                            SLV_NUM    = 2,
    parameter int                            PRI_WIDTH  = 1,
    parameter int                            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH*SLV_NUM-1:0] SLV_BASE   = {32'h2000_0000, 32'h0000_0000},
    parameter logic [ADDR_WIDTH*SLV_NUM-1:0] SLV_MASK   = {32'hF000_0000, 32'hF000_0000}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hready,
    input  logic [PRI_WIDTH-1:0]  cfg_pri,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [SLV_NUM-1:0]    req,
    output logic [PRI_WIDTH-1:0]  pri,
    input  logic [SLV_NUM-1:0]    gnt,
    input  logic                  arb_ready,
    output logic [1:0]            o_htrans,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic                  o_hwrite,
    output logic [2:0]            o_hsize,
    output logic [2:0]            o_hburst,
    output logic [3:0]            o_hprot,
    input  logic                  s_hreadyout,
    input  logic                  s_hresp
);

    localparam int IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;

    state_e                  state_q, state_d, cap_st;
    logic [SLV_NUM-1:0]      hit, oh_q;
    logic [IDX_W-1:0]        idx, idx_q;
    logic                    miss, accept, cap, fwd;
    logic [ADDR_WIDTH-1:0]   haddr_q, o_haddr_q;
    logic [PRI_WIDTH-1:0]    pri_q;
    ctl_t                    ctl_in, ctl_q, o_ctl_q, o_ctl;

    ahb_mtx_addr_dec #(
        .SLV_NUM    (SLV_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .haddr_i (haddr),
        .hit_o   (hit),
        .idx_o   (idx),
        .miss_o  (miss)
    );

    assign ctl_in = '{htrans: htrans, hwrite: hwrite, hsize: hsize, hburst: hburst, hprot: hprot};

    // A new address phase is only taken when the master sees this stage as ready
    assign accept = (state_q == ST_IDLE) || (state_q == ST_ERR2) || (state_q == ST_DATA && s_hreadyout);
    assign cap    = accept && hsel && hready && is_active(htrans);
    assign cap_st = miss ? ST_ERR1 : ST_WAIT_GNT;
    assign fwd    = (state_q == ST_WAIT_GNT) && gnt[idx_q] && arb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     state_d = cap ? cap_st : ST_IDLE;
            ST_WAIT_GNT: state_d = fwd ? ST_DATA : ST_WAIT_GNT;
            ST_DATA:     state_d = !s_hreadyout ? ST_DATA : cap ? cap_st : ST_IDLE;
            ST_ERR1:     state_d = ST_ERR2;
            ST_ERR2:     state_d = cap ? cap_st : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        req       = '0;
        o_htrans  = HTRANS_IDLE;
        unique case (state_q)
            ST_WAIT_GNT: begin
                req       = oh_q;
                hreadyout = 1'b0;
                o_htrans  = fwd ? ctl_q.htrans : HTRANS_IDLE;
            end
            ST_DATA: begin
                hreadyout = s_hreadyout;
                hresp     = s_hresp;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2:  hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Hold registers for the captured phase and the last forwarded phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haddr_q   <= '0;
            ctl_q     <= '0;
            pri_q     <= '0;
            idx_q     <= '0;
            oh_q      <= '0;
            o_haddr_q <= '0;
            o_ctl_q   <= '0;
        end else begin
            if (cap) begin
                haddr_q <= haddr;
                ctl_q   <= ctl_in;
                pri_q   <= cfg_pri;
                idx_q   <= idx;
                oh_q    <= hit & (~hit + SLV_NUM'(1));
            end
            if (fwd) begin
                o_haddr_q <= haddr_q;
                o_ctl_q   <= ctl_q;
            end
        end
    end

    assign pri      = pri_q;
    assign o_ctl    = fwd ? ctl_q : o_ctl_q;
    assign o_haddr  = fwd ? haddr_q : o_haddr_q;
    assign o_hwrite = o_ctl.hwrite;
    assign o_hsize  = o_ctl.hsize;
    assign o_hburst = o_ctl.hburst;
    assign o_hprot  = o_ctl.hprot;

endmodule

// File: tb/tb_ahb_mtx_req_stage.sv
// tb_ahb_mtx_req_stage: directed scenarios for the matrix request stage with hand-computed expectations
module tb_ahb_mtx_req_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hready;
    logic [0:0]  cfg_pri;
    logic        hreadyout;
    logic        hresp;
    logic [1:0]  req;
    logic [0:0]  pri;
    logic [1:0]  gnt;
    logic        arb_ready;
    logic [1:0]  o_htrans;
    logic [31:0] o_haddr;
    logic        o_hwrite;
    logic [2:0]  o_hsize;
    logic [2:0]  o_hburst;
    logic [3:0]  o_hprot;
    logic        s_hreadyout;
    logic        s_hresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // The master's bus-ready is this stage's own hreadyout, as in a real matrix
    assign hready = hreadyout;

    ahb_mtx_req_stage dut (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready), .cfg_pri(cfg_pri),
        .hreadyout(hreadyout), .hresp(hresp), .req(req), .pri(pri), .gnt(gnt), .arb_ready(arb_ready),
        .o_htrans(o_htrans), .o_haddr(o_haddr), .o_hwrite(o_hwrite), .o_hsize(o_hsize),
        .o_hburst(o_hburst), .o_hprot(o_hprot), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp)
    );

    task automatic present(input logic [31:0] a, input logic w, input logic [0:0] p);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; cfg_pri = p;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_hreadyout got %b exp 1", hreadyout); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL rst_hresp got %b exp 0", hresp); end
        n_checks++; if (req !== 2'b00) begin n_fail++; $display("FAIL rst_req got %b exp 00", req); end
        n_checks++; if (o_htrans !== 2'b00) begin n_fail++; $display("FAIL rst_o_htrans got %b exp 00", o_htrans); end
        n_checks++; if (o_haddr !== 32'h0) begin n_fail++; $display("FAIL rst_o_haddr got %h exp 0", o_haddr); end
        n_checks++; if (pri !== 1'b0) begin n_fail++; $display("FAIL rst_pri got %b exp 0", pri); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        @(negedge clk); present(32'h2000_0010, 1'b1, 1'b0); hsize = 3'd2; #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL wr_idle_ready got %b exp 1", hreadyout); end
        n_checks++; if (req !== 2'b00) begin n_fail++; $display("FAIL wr_idle_req got %b exp 00", req); end
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; #1;
        n_checks++; if (req !== 2'b10) begin n_fail++; $display("FAIL wr_w1_req got %b exp 10", req); end
        n_checks++; if (hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_w1_ready got %b exp 0", hreadyout); end
        n_checks++; if (o_htrans !== 2'b00) begin n_fail++; $display("FAIL wr_w1_o_htrans got %b exp 00", o_htrans); end
        @(negedge clk); cfg_pri = 1'b1; #1;
        n_checks++; if (req !== 2'b10) begin n_fail++; $display("FAIL wr_w2_req got %b exp 10", req); end
        n_checks++; if (pri !== 1'b0) begin n_fail++; $display("FAIL wr_w2_pri got %b exp 0", pri); end
        @(negedge clk); gnt = 2'b10; arb_ready = 1'b1; #1;
        n_checks++; if (req !== 2'b10) begin n_fail++; $display("FAIL wr_w3_req got %b exp 10", req); end
        n_checks++; if (hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_w3_ready got %b exp 0", hreadyout); end
        n_checks++; if (pri !== 1'b0) begin n_fail++; $display("FAIL wr_w3_pri got %b exp 0", pri); end
        n_checks++; if (o_htrans !== 2'b10) begin n_fail++; $display("FAIL wr_fwd_htrans got %b exp 10", o_htrans); end
        n_checks++; if (o_haddr !== 32'h2000_0010) begin n_fail++; $display("FAIL wr_fwd_haddr got %h exp 20000010", o_haddr); end
        n_checks++; if (o_hwrite !== 1'b1) begin n_fail++; $display("FAIL wr_fwd_hwrite got %b exp 1", o_hwrite); end
        n_checks++; if (o_hsize !== 3'd2) begin n_fail++; $display("FAIL wr_fwd_hsize got %0d exp 2", o_hsize); end
        @(negedge clk); gnt = 2'b00; arb_ready = 1'b0; s_hreadyout = 1'b0; cfg_pri = 1'b0; #1;
        n_checks++; if (hreadyout !== 1'b0) begin n_fail++; $display("FAIL wr_data_wait got %b exp 0", hreadyout); end
        n_checks++; if (req !== 2'b00) begin n_fail++; $display("FAIL wr_data_req got %b exp 00", req); end
        n_checks++; if (o_htrans !== 2'b00) begin n_fail++; $display("FAIL wr_data_o_htrans got %b exp 00", o_htrans); end
        n_checks++; if (o_haddr !== 32'h2000_0010) begin n_fail++; $display("FAIL wr_data_hold_haddr got %h exp 20000010", o_haddr); end
        @(negedge clk); s_hreadyout = 1'b1; #1;
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL wr_okay got %b/%b exp 1/0", hreadyout, hresp); end
        @(negedge clk); #1;
        n_checks++; if (hreadyout !== 1'b1 || req !== 2'b00) begin n_fail++; $display("FAIL wr_back_idle got %b/%b exp 1/00", hreadyout, req); end
    endtask

    task automatic test_error;
        @(negedge clk); present(32'h5000_0000, 1'b0, 1'b0); #1;
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; #1;
        n_checks++; if (req !== 2'b00) begin n_fail++; $display("FAIL err1_req got %b exp 00", req); end
        n_checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL err1 got %b/%b exp 0/1", hreadyout, hresp); end
        @(negedge clk); #1;
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL err2 got %b/%b exp 1/1", hreadyout, hresp); end
        @(negedge clk); #1;
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL err_idle got %b/%b exp 1/0", hreadyout, hresp); end
    endtask

    task automatic test_wrong_gnt;
        @(negedge clk); present(32'h2000_0004, 1'b1, 1'b0); #1;
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; gnt = 2'b01; arb_ready = 1'b1; #1;
        n_checks++; if (o_htrans !== 2'b00) begin n_fail++; $display("FAIL wg_other_fwd got %b exp 00", o_htrans); end
        n_checks++; if (req !== 2'b10 || hreadyout !== 1'b0) begin n_fail++; $display("FAIL wg_other_hold got %b/%b exp 10/0", req, hreadyout); end
        @(negedge clk); gnt = 2'b10; arb_ready = 1'b0; #1;
        n_checks++; if (o_htrans !== 2'b00) begin n_fail++; $display("FAIL wg_noready_fwd got %b exp 00", o_htrans); end
        n_checks++; if (req !== 2'b10 || hreadyout !== 1'b0) begin n_fail++; $display("FAIL wg_noready_hold got %b/%b exp 10/0", req, hreadyout); end
        @(negedge clk); arb_ready = 1'b1; #1;
        n_checks++; if (o_htrans !== 2'b10 || o_haddr !== 32'h2000_0004) begin n_fail++; $display("FAIL wg_fwd got %b/%h exp 10/20000004", o_htrans, o_haddr); end
        @(negedge clk); gnt = 2'b00; arb_ready = 1'b0; #1;
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL wg_okay got %b/%b exp 1/0", hreadyout, hresp); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); present(32'h0000_0100, 1'b1, 1'b0); #1;
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; gnt = 2'b01; arb_ready = 1'b1; #1;
        n_checks++; if (req !== 2'b01) begin n_fail++; $display("FAIL b2b_a_req got %b exp 01", req); end
        n_checks++; if (o_htrans !== 2'b10 || o_haddr !== 32'h0000_0100) begin n_fail++; $display("FAIL b2b_a_fwd got %b/%h exp 10/00000100", o_htrans, o_haddr); end
        @(negedge clk); gnt = 2'b00; arb_ready = 1'b0; present(32'h2000_0020, 1'b0, 1'b1); #1;
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL b2b_a_done got %b exp 1", hreadyout); end
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; #1;
        n_checks++; if (req !== 2'b10 || hreadyout !== 1'b0) begin n_fail++; $display("FAIL b2b_direct_wait got %b/%b exp 10/0", req, hreadyout); end
        n_checks++; if (pri !== 1'b1) begin n_fail++; $display("FAIL b2b_pri got %b exp 1", pri); end
        n_checks++; if (o_haddr !== 32'h0000_0100) begin n_fail++; $display("FAIL b2b_hold_haddr got %h exp 00000100", o_haddr); end
        @(negedge clk); gnt = 2'b10; arb_ready = 1'b1; #1;
        n_checks++; if (o_htrans !== 2'b10 || o_haddr !== 32'h2000_0020 || o_hwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_b_fwd got %b/%h/%b exp 10/20000020/0", o_htrans, o_haddr, o_hwrite); end
        @(negedge clk); gnt = 2'b00; arb_ready = 1'b0; cfg_pri = 1'b0; #1;
        n_checks++; if (hreadyout !== 1'b1 || req !== 2'b00) begin n_fail++; $display("FAIL b2b_b_done got %b/%b exp 1/00", hreadyout, req); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); present(32'h2000_0008, 1'b1, 1'b0); #1;
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; #1;
        n_checks++; if (req !== 2'b10) begin n_fail++; $display("FAIL rw_pre_req got %b exp 10", req); end
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++; if (req !== 2'b00 || o_htrans !== 2'b00) begin n_fail++; $display("FAIL rw_req got %b/%b exp 00/00", req, o_htrans); end
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL rw_resp got %b/%b exp 1/0", hreadyout, hresp); end
        @(negedge clk); rst_n = 1'b1; #1;
        @(negedge clk); #1;
        n_checks++; if (req !== 2'b00 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL rw_idle got %b/%b exp 00/1", req, hreadyout); end
        @(negedge clk); present(32'h0000_0200, 1'b0, 1'b0); #1;
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; gnt = 2'b01; arb_ready = 1'b1; #1;
        @(negedge clk); gnt = 2'b00; arb_ready = 1'b0; s_hreadyout = 1'b0; s_hresp = 1'b1; #1;
        n_checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL rd_pass got %b/%b exp 0/1", hreadyout, hresp); end
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL rd_resp got %b/%b exp 1/0", hreadyout, hresp); end
        n_checks++; if (o_haddr !== 32'h0 || o_htrans !== 2'b00) begin n_fail++; $display("FAIL rd_o got %h/%b exp 0/00", o_haddr, o_htrans); end
        @(negedge clk); rst_n = 1'b1; s_hreadyout = 1'b1; s_hresp = 1'b0; #1;
        @(negedge clk); #1;
        n_checks++; if (req !== 2'b00 || hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL rd_idle got %b/%b/%b exp 00/1/0", req, hreadyout, hresp); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        hburst = 3'd0; hprot = 4'd0; cfg_pri = 1'b0; gnt = 2'b00; arb_ready = 1'b0;
        s_hreadyout = 1'b1; s_hresp = 1'b0;
        test_reset;
        test_single_write;
        test_error;
        test_wrong_gnt;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
